// File: rtl/imem_fetch_sequencer_if.sv
// Bus between the fetch sequencer, the instruction memory and the execute stage.
// master = sequencer side, slave = memory/execute side.
interface imem_fetch_sequencer_if #(
    parameter int ADDR_W  = 6,
    parameter int INSTR_W = 17
);
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               IR_enable;
    logic [INSTR_W-1:0] ir;
    logic               ir_valid;
    logic               exec_done;
    logic               jump_req;
    logic [ADDR_W-1:0]  jump_target;
    logic               skip_req;
    logic [3:0]         skip_cnt;

    modport master (
        output imem_addr, IR_enable, ir, ir_valid,
        input  imem_rdata, exec_done, jump_req, jump_target, skip_req, skip_cnt
    );

    modport slave (
        input  imem_addr, IR_enable, ir, ir_valid,
        output imem_rdata, exec_done, jump_req, jump_target, skip_req, skip_cnt
    );
endinterface

// File: rtl/imem_fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, latches the IR, hands it to execute, halts on a zero word.
// Define FETCH_PERF_CNT_EN to add the retired_cnt / skip_cnt_total performance counters.
module imem_fetch_sequencer #(
    parameter int ADDR_W   = 6,
    parameter int INSTR_W  = 17,
    parameter int RESET_PC = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    imem_fetch_sequencer_if.master        bus,
    output logic                          halted,
    output logic [ADDR_W-1:0]             pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]                   retired_cnt,
    output logic [15:0]                   skip_cnt_total
`endif
);

    typedef enum logic [2:0] {IDLE, FETCH, LATCH, EXEC, HALT} state_t;

    localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  pc_q, pc_nxt;
    logic [INSTR_W-1:0] ir_q;
    logic               ir_load;

    // PC arithmetic wraps silently modulo the memory depth.
    function automatic logic [ADDR_W-1:0] pc_advance(input logic [ADDR_W-1:0] base,
                                                     input logic [3:0]        cnt);
        return base + ADDR_W'(cnt) + ADDR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        ir_load   = 1'b0;
        case (state)
            IDLE, HALT: begin
                if (start) begin
                    state_nxt = FETCH;
                    pc_nxt    = PC_RST;
                end
            end
            FETCH: state_nxt = LATCH;
            LATCH: begin
                ir_load   = 1'b1;
                state_nxt = (bus.imem_rdata == '0) ? HALT : EXEC;
            end
            EXEC: begin
                if (bus.exec_done) begin
                    state_nxt = FETCH;
                    if (bus.jump_req)      pc_nxt = bus.jump_target;
                    else if (bus.skip_req) pc_nxt = pc_advance(pc_q, bus.skip_cnt);
                    else                   pc_nxt = pc_advance(pc_q, 4'd0);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= PC_RST;
            ir_q <= '0;
        end else begin
            pc_q <= pc_nxt;
            if (ir_load) ir_q <= bus.imem_rdata;
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.IR_enable = (state == LATCH);
    assign bus.ir_valid  = (state == EXEC);
    assign bus.ir        = ir_q;
    assign halted        = (state == HALT);
    assign pc            = pc_q;

`ifdef FETCH_PERF_CNT_EN
    logic restart, accept, skip_taken;
    logic [15:0] retired_q, skip_tot_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign restart    = ((state == IDLE) || (state == HALT)) && start;
    assign accept     = (state == EXEC) && bus.exec_done;
    // A skip overridden by a simultaneous jump is not counted.
    assign skip_taken = accept && bus.skip_req && !bus.jump_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q  <= '0;
            skip_tot_q <= '0;
        end else if (restart) begin
            retired_q  <= '0;
            skip_tot_q <= '0;
        end else begin
            if (accept)     retired_q  <= sat_inc(retired_q);
            if (skip_taken) skip_tot_q <= sat_inc(skip_tot_q);
        end
    end

    assign retired_cnt    = retired_q;
    assign skip_cnt_total = skip_tot_q;
`endif

endmodule

// File: doc/imem_fetch_sequencer.md
Name: imem_fetch_sequencer

Overview:
- Sequences the 64-entry x 17-bit instruction memory. Owns the 6-bit program counter (PC), drives the memory address and IR_enable, and latches the fetched word into the instruction register (IR).
- Hands the IR to the execute stage and waits for completion.
- Applies sequential / jump / branch-skip PC updates.
- Halts on an all-zero instruction word.
- Sits between the instruction memory and the CPU control unit.

Parameters:
- ADDR_W, 6, PC and memory address width (memory depth = 2**ADDR_W).
- INSTR_W, 17, instruction word width.
- RESET_PC, 1, PC value loaded on reset and on restart. Address 0 is reserved as a null word.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  level; leaves IDLE/HALT and begins fetching at RESET_PC.
- imem_addr  output  ADDR_W  address to instruction memory (equals PC).
- imem_rdata  input  INSTR_W  combinational read data from instruction memory.
- IR_enable  output  1  one-cycle strobe in LATCH; instruction register loads imem_rdata.
- ir  output  INSTR_W  latched instruction register.
- ir_valid  output  1  high while the execute stage owns the IR (EXEC state).
- exec_done  input  1  execute stage finished the current instruction; sampled only in EXEC.
- jump_req  input  1  with exec_done: absolute jump.
- jump_target  input  ADDR_W  absolute target for jump_req.
- skip_req  input  1  with exec_done: branch taken, skip skip_cnt instructions.
- skip_cnt  input  4  branch skip count (instruction bits [3:0]).
- halted  output  1  high in HALT.
- pc  output  ADDR_W  current PC, for debug.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, PC=RESET_PC, ir=0, ir_valid=0, IR_enable=0, halted=0, imem_addr=RESET_PC. Reset mid-instruction abandons it immediately; no partial PC update survives.
- States: IDLE, FETCH, LATCH, EXEC, HALT.
- IDLE: wait. start=1 -> FETCH; PC=RESET_PC.
- FETCH: one cycle; imem_addr=PC settles. Then -> LATCH.
- LATCH: IR_enable=1 for exactly this cycle; ir <= imem_rdata at the clock edge.
  - If imem_rdata==0 -> HALT; ir still loads 0.
  - Otherwise -> EXEC.
- EXEC: ir_valid=1; hold until exec_done=1. On the exec_done edge the next PC is chosen by priority:
  - jump_req -> PC=jump_target.
  - else skip_req -> PC=PC+1+skip_cnt.
  - else PC=PC+1.
  - Then -> FETCH.
- Fetch latency: 2 cycles from entering FETCH to ir valid in EXEC. Minimum instruction period is 3 cycles (FETCH, LATCH, EXEC with exec_done same cycle).
- PC arithmetic is modulo 2**ADDR_W: PC=63 +1 -> 0; PC=60 with skip_cnt=5 -> 2. Wrap is silent.
- jump_req and skip_req both high: jump wins, skip ignored.
- exec_done, jump_req and skip_req are ignored outside EXEC.
- HALT: halted=1, ir_valid=0, PC frozen at the address of the zero word. start=1 -> FETCH with PC=RESET_PC and halted cleared on that edge.
- start held high does not retrigger while running; it is only sampled in IDLE/HALT.
- IR_enable is never high in any state other than LATCH.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds output retired_cnt [15:0]: increments on each exec_done accepted in EXEC, saturates at 16'hFFFF, cleared by reset and by restart from HALT/IDLE.
  - Adds output skip_cnt_total [15:0]: counts accepted skip_req (not overridden by jump), same saturation and clear rules.
- Undefined: neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Reset then start=1, memory word 1=16'h0678, exec_done after 1 cycle -> imem_addr=1, IR_enable pulses once 2 cycles after start, ir=16'h0678, next imem_addr=2.
- Fibonacci loop (words 1-6 as program, word 7 nonzero, word 8=0), bench asserts skip_req at word 5 on the 3rd pass and jump_req target 1 at word 6 otherwise -> PC sequence 1..6,1..6,1..5,8, then halted=1, pc=8.
- PC=62, exec_done with skip_req, skip_cnt=3 -> next PC=2 (wrap).
- jump_req=1 target 9 and skip_req=1 skip_cnt=2 together at PC=4 -> next PC=9.
- rst_n low in EXEC with ir_valid=1 -> all outputs at reset values immediately, before the next clock edge. After release and start -> fetch at PC=1.
- FETCH_PERF_CNT_EN: 5 instructions retired, 1 with skip -> retired_cnt=5, skip_cnt_total=1; restart from HALT -> both counters read 0.
